v_state_mrep: RTL and testbench



---
 rtl/v_pkg.sv | 14 +
 rtl/sram1r1w.sv | 31 +++
 rtl/v_state_mrep_init.sv | 59 +++++
 rtl/v_state_mrep.sv | 123 ++++++++++++
 tb/tb_v_state_mrep.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/v_pkg.sv
// Shared types and helpers for the v list engine state store.
package v_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } v_state_mrep_fsm_t;

  // Address width for an n-entry store; a single entry still needs one bit.
  function automatic int v_addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram1r1w.sv
// Simple 1R1W memory: synchronous write, registered read returning pre-write contents on collision.
module sram1r1w #(
  parameter int DEPTH = 64,
  parameter int W     = 32,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (i_re) rdata_d = mem[i_raddr];
  end

  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/v_state_mrep_init.sv
// Initialisation sequencer: sweeps every entry once after reset or on request, flagging busy meanwhile.
module v_state_mrep_init import v_pkg::*; #(
  parameter int N = 64,
  localparam int AW = v_addr_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_init_req,
  output logic          o_busy_r,
  output logic          o_init_we,
  output logic [AW-1:0] o_init_addr
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  v_state_mrep_fsm_t state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      IDLE: begin
        if (i_init_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
    busy_d = (state_d == INIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy_r    = busy_q;
  assign o_init_we   = (state_q == INIT);
  assign o_init_addr = cnt_q;

endmodule

// File: rtl/v_state_mrep.sv
// Per-context state store: one write port fanned out to R replicated 1R1W memories,
// with re-initialisation, write-first bypass and out-of-range/busy access flagging.
module v_state_mrep import v_pkg::*; #(
  parameter int          N        = 64,
  parameter int          W        = 32,
  parameter int          R        = 2,
  parameter logic [W-1:0] INIT_VAL = '0,
  parameter int          BYPASS   = 1,
  localparam int         AW       = v_addr_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_init_req,
  output logic            o_busy_r,
  input  logic            i_wen,
  input  logic [AW-1:0]   i_waddr,
  input  logic [W-1:0]    i_wdata,
  output logic            o_wdrop_r,
  input  logic [R-1:0]    i_ren,
  input  logic [R*AW-1:0] i_raddr,
  output logic [R-1:0]    o_rvld_r,
  output logic [R*W-1:0]  o_rdata,
  output logic [R-1:0]    o_rerr_r
);

  // One extra bit so the range check never wraps, even when N == 2**AW.
  localparam logic [AW:0] N_LIM = (AW+1)'(N);

  logic          busy;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic          wr_ok;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;
  logic          wdrop_q, wdrop_d;

  v_state_mrep_init #(.N(N)) u_init (
    .clk         (clk),
    .rst         (rst),
    .i_init_req  (i_init_req),
    .o_busy_r    (busy),
    .o_init_we   (init_we),
    .o_init_addr (init_addr)
  );

  always_comb begin
    wr_ok     = i_wen && !busy && ({1'b0, i_waddr} < N_LIM);
    wdrop_d   = i_wen && !wr_ok;
    mem_we    = init_we || wr_ok;
    mem_waddr = init_we ? init_addr : i_waddr;
    mem_wdata = init_we ? INIT_VAL : i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) wdrop_q <= 1'b0;
    else     wdrop_q <= wdrop_d;
  end

  assign o_busy_r  = busy;
  assign o_wdrop_r = wdrop_q;

  for (genvar r = 0; r < R; r++) begin : g_port
    logic [AW-1:0] raddr;
    logic          rd_ok;
    logic [W-1:0]  mem_rdata;
    logic [W-1:0]  rdata;
    logic          rvld_q, rvld_d;
    logic          rerr_q, rerr_d;
    logic          byp_q, byp_d;
    logic [W-1:0]  byp_data_q, byp_data_d;
    logic [W-1:0]  hold_q, hold_d;

    assign raddr = i_raddr[r*AW +: AW];

    // The output holds its last value between reads, so the visible word is itself remembered.
    always_comb begin
      rd_ok      = i_ren[r] && !busy && ({1'b0, raddr} < N_LIM);
      rvld_d     = i_ren[r];
      rerr_d     = i_ren[r] && !rd_ok;
      byp_d      = (BYPASS != 0) && rd_ok && wr_ok && (raddr == i_waddr);
      byp_data_d = byp_d ? i_wdata : byp_data_q;
      rdata      = hold_q;
      if (rvld_q) begin
        if (rerr_q)     rdata = '0;
        else if (byp_q) rdata = byp_data_q;
        else            rdata = mem_rdata;
      end
      hold_d = rdata;
    end

    sram1r1w #(.DEPTH(N), .W(W), .AW(AW)) u_mem (
      .clk     (clk),
      .i_we    (mem_we),
      .i_waddr (mem_waddr),
      .i_wdata (mem_wdata),
      .i_re    (rd_ok),
      .i_raddr (raddr),
      .o_rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        rvld_q     <= 1'b0;
        rerr_q     <= 1'b0;
        byp_q      <= 1'b0;
        byp_data_q <= '0;
        hold_q     <= '0;
      end else begin
        rvld_q     <= rvld_d;
        rerr_q     <= rerr_d;
        byp_q      <= byp_d;
        byp_data_q <= byp_data_d;
        hold_q     <= hold_d;
      end
    end

    assign o_rvld_r[r]         = rvld_q;
    assign o_rerr_r[r]         = rerr_q;
    assign o_rdata[r*W +: W]   = rdata;
  end

endmodule

// File: tb/tb_v_state_mrep.sv
// Scoreboard bench for v_state_mrep (N=48, two read ports, write-first bypass).
module tb_v_state_mrep;

  localparam int N = 48;
  localparam int W = 32;
  localparam int R = 2;
  localparam int AW = 6;
  localparam logic [W-1:0] INIT_VAL = 32'h0BAD_F00D;

  typedef struct {
    int         port;
    logic       vld;
    logic       err;
    logic [W-1:0] data;
  } rd_exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_init_req;
  logic            o_busy_r;
  logic            i_wen;
  logic [AW-1:0]   i_waddr;
  logic [W-1:0]    i_wdata;
  logic            o_wdrop_r;
  logic [R-1:0]    i_ren;
  logic [R*AW-1:0] i_raddr;
  logic [R-1:0]    o_rvld_r;
  logic [R*W-1:0]  o_rdata;
  logic [R-1:0]    o_rerr_r;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mem_m [N];
  logic [W-1:0] last_m [R];
  rd_exp_t      rd_sb[$];
  logic         wd_sb[$];

  always #5 clk = ~clk;

  v_state_mrep #(
    .N(N), .W(W), .R(R), .INIT_VAL(INIT_VAL), .BYPASS(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_init_req (i_init_req),
    .o_busy_r   (o_busy_r),
    .i_wen      (i_wen),
    .i_waddr    (i_waddr),
    .i_wdata    (i_wdata),
    .o_wdrop_r  (o_wdrop_r),
    .i_ren      (i_ren),
    .i_raddr    (i_raddr),
    .o_rvld_r   (o_rvld_r),
    .o_rdata    (o_rdata),
    .o_rerr_r   (o_rerr_r)
  );

  // Drive one cycle of stimulus, push the expected results, then advance past the edge.
  task automatic drive_step(input logic rst_in, input logic init, input logic wen, input int waddr,
                            input logic [W-1:0] wdata, input logic [R-1:0] ren,
                            input int ra0, input int ra1, input logic busy);
    rd_exp_t e;
    logic    wok;
    int      ra;
    rst        = rst_in;
    i_init_req = init;
    i_wen      = wen;
    i_waddr    = AW'(waddr);
    i_wdata    = wdata;
    i_ren      = ren;
    i_raddr    = {AW'(ra1), AW'(ra0)};
    wok = !rst_in && wen && !busy && (waddr < N);
    wd_sb.push_back(!rst_in && wen && !wok);
    if (wok) mem_m[waddr] = wdata;
    for (int p = 0; p < R; p++) begin
      ra = (p == 0) ? ra0 : ra1;
      e.port = p;
      if (rst_in) begin
        e.vld = 1'b0; e.err = 1'b0; e.data = '0;
      end else if (!ren[p]) begin
        e.vld = 1'b0; e.err = 1'b0; e.data = last_m[p];
      end else if (busy || ra >= N) begin
        e.vld = 1'b1; e.err = 1'b1; e.data = '0;
      end else begin
        e.vld = 1'b1; e.err = 1'b0; e.data = mem_m[ra];
      end
      last_m[p] = e.data;
      rd_sb.push_back(e);
    end
    @(posedge clk);
    #1;
    rst        = 1'b0;
    i_init_req = 1'b0;
    i_wen      = 1'b0;
    i_ren      = '0;
  endtask

  task automatic test_reset();
    int busy_cycles;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (o_busy_r !== 1'b1 || o_rvld_r !== '0 || o_rerr_r !== '0 || o_rdata !== '0 || o_wdrop_r !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_values: got busy=%b rvld=%b rerr=%b rdata=%h wdrop=%b, expected 1 00 00 0 0",
               o_busy_r, o_rvld_r, o_rerr_r, o_rdata, o_wdrop_r);
    end
    rst = 1'b0;
    busy_cycles = 0;
    while (o_busy_r === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (busy_cycles != N) begin
      fails++;
      $display("[TB] FAIL reset_sweep busy cycles: got %0d, expected %0d", busy_cycles, N);
    end
    for (int a = 0; a < N; a++) mem_m[a] = INIT_VAL;
    for (int p = 0; p < R; p++) last_m[p] = '0;
  endtask

  task automatic test_init_contents();
    rd_exp_t e;
    logic    wexp;
    for (int a = 0; a < N; a++) begin
      drive_step(0, 0, 0, 0, '0, 2'b11, a, N - 1 - a, 0);
      for (int p = 0; p < R; p++) begin
        e = rd_sb.pop_front();
        tests++;
        if (o_rvld_r[e.port] !== e.vld || o_rdata[e.port*W +: W] !== e.data ||
            (e.vld && o_rerr_r[e.port] !== e.err)) begin
          fails++;
          $display("[TB] FAIL init_contents p%0d: got vld=%b err=%b data=%h, expected vld=%b err=%b data=%h",
                   e.port, o_rvld_r[e.port], o_rerr_r[e.port], o_rdata[e.port*W +: W], e.vld, e.err, e.data);
        end
      end
      wexp = wd_sb.pop_front();
      tests++;
      if (o_wdrop_r !== wexp) begin
        fails++;
        $display("[TB] FAIL init_contents wdrop: got %b, expected %b", o_wdrop_r, wexp);
      end
    end
  endtask

  task automatic test_write_read();
    rd_exp_t e;
    logic    wexp;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       drive_step(0, 0, 1, 5, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
        1:       drive_step(0, 0, 0, 0, '0, 2'b11, 5, 5, 0);
        2:       drive_step(0, 0, 0, 0, '0, 2'b00, 0, 0, 0);
        default: drive_step(0, 0, 0, 0, '0, 2'b01, 4, 0, 0);
      endcase
      for (int p = 0; p < R; p++) begin
        e = rd_sb.pop_front();
        tests++;
        if (o_rvld_r[e.port] !== e.vld || o_rdata[e.port*W +: W] !== e.data ||
            (e.vld && o_rerr_r[e.port] !== e.err)) begin
          fails++;
          $display("[TB] FAIL write_read p%0d: got vld=%b err=%b data=%h, expected vld=%b err=%b data=%h",
                   e.port, o_rvld_r[e.port], o_rerr_r[e.port], o_rdata[e.port*W +: W], e.vld, e.err, e.data);
        end
      end
      wexp = wd_sb.pop_front();
      tests++;
      if (o_wdrop_r !== wexp) begin
        fails++;
        $display("[TB] FAIL write_read wdrop: got %b, expected %b", o_wdrop_r, wexp);
      end
    end
  endtask

  task automatic test_collision();
    rd_exp_t e;
    logic    wexp;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       drive_step(0, 0, 1, 7, 32'h0000_0011, 2'b00, 0, 0, 0);
        1:       drive_step(0, 0, 1, 7, 32'h0000_0022, 2'b11, 7, 7, 0);
        2:       drive_step(0, 0, 1, 8, 32'h0000_0033, 2'b11, 9, 8, 0);
        default: drive_step(0, 0, 0, 0, '0, 2'b11, 7, 8, 0);
      endcase
      for (int p = 0; p < R; p++) begin
        e = rd_sb.pop_front();
        tests++;
        if (o_rvld_r[e.port] !== e.vld || o_rdata[e.port*W +: W] !== e.data ||
            (e.vld && o_rerr_r[e.port] !== e.err)) begin
          fails++;
          $display("[TB] FAIL collision p%0d: got vld=%b err=%b data=%h, expected vld=%b err=%b data=%h",
                   e.port, o_rvld_r[e.port], o_rerr_r[e.port], o_rdata[e.port*W +: W], e.vld, e.err, e.data);
        end
      end
      wexp = wd_sb.pop_front();
      tests++;
      if (o_wdrop_r !== wexp) begin
        fails++;
        $display("[TB] FAIL collision wdrop: got %b, expected %b", o_wdrop_r, wexp);
      end
    end
  endtask

  task automatic test_out_of_range();
    rd_exp_t e;
    logic    wexp;
    for (int s = 0; s < N + 3; s++) begin
      case (s)
        0:       drive_step(0, 0, 1, 50, 32'hFFFF_0050, 2'b00, 0, 0, 0);
        1:       drive_step(0, 0, 1, 48, 32'hFFFF_0048, 2'b11, 50, 63, 0);
        2:       drive_step(0, 0, 1, 47, 32'h4747_4747, 2'b11, 48, 47, 0);
        default: drive_step(0, 0, 0, 0, '0, 2'b11, s - 3, N + 2 - s, 0);
      endcase
      for (int p = 0; p < R; p++) begin
        e = rd_sb.pop_front();
        tests++;
        if (o_rvld_r[e.port] !== e.vld || o_rdata[e.port*W +: W] !== e.data ||
            (e.vld && o_rerr_r[e.port] !== e.err)) begin
          fails++;
          $display("[TB] FAIL out_of_range p%0d: got vld=%b err=%b data=%h, expected vld=%b err=%b data=%h",
                   e.port, o_rvld_r[e.port], o_rerr_r[e.port], o_rdata[e.port*W +: W], e.vld, e.err, e.data);
        end
      end
      wexp = wd_sb.pop_front();
      tests++;
      if (o_wdrop_r !== wexp) begin
        fails++;
        $display("[TB] FAIL out_of_range wdrop: got %b, expected %b", o_wdrop_r, wexp);
      end
    end
  endtask

  task automatic test_reinit();
    rd_exp_t e;
    logic    wexp;
    logic    bexp;
    for (int s = 0; s < 2 * N + 50; s++) begin
      bexp = (s >= N + 1) && (s <= 2 * N);
      tests++;
      if (o_busy_r !== bexp) begin
        fails++;
        $display("[TB] FAIL reinit busy cycle %0d: got %b, expected %b", s, o_busy_r, bexp);
      end
      if (s < N)                drive_step(0, 0, 1, s, {16'hC000, 16'(s)}, 2'b00, 0, 0, bexp);
      else if (s == N)          drive_step(0, 1, 0, 0, '0, 2'b00, 0, 0, bexp);
      else if (s == N + 5)      drive_step(0, 0, 1, 3, 32'h1234_5678, 2'b00, 0, 0, bexp);
      else if (s == N + 6)      drive_step(0, 0, 0, 0, '0, 2'b11, 4, 10, bexp);
      else if (s == N + 10)     drive_step(0, 1, 1, 60, 32'h6060_6060, 2'b00, 0, 0, bexp);
      else if (s <= 2 * N + 1)  drive_step(0, 0, 0, 0, '0, 2'b00, 0, 0, bexp);
      else                      drive_step(0, 0, 0, 0, '0, 2'b11, s - 2 * N - 2, 3 * N + 1 - s, bexp);
      if (s == N) begin
        for (int a = 0; a < N; a++) mem_m[a] = INIT_VAL;
      end
      for (int p = 0; p < R; p++) begin
        e = rd_sb.pop_front();
        tests++;
        if (o_rvld_r[e.port] !== e.vld || o_rdata[e.port*W +: W] !== e.data ||
            (e.vld && o_rerr_r[e.port] !== e.err)) begin
          fails++;
          $display("[TB] FAIL reinit p%0d cycle %0d: got vld=%b err=%b data=%h, expected vld=%b err=%b data=%h",
                   e.port, s, o_rvld_r[e.port], o_rerr_r[e.port], o_rdata[e.port*W +: W], e.vld, e.err, e.data);
        end
      end
      wexp = wd_sb.pop_front();
      tests++;
      if (o_wdrop_r !== wexp) begin
        fails++;
        $display("[TB] FAIL reinit wdrop cycle %0d: got %b, expected %b", s, o_wdrop_r, wexp);
      end
    end
  endtask

  task automatic test_rst_mid_sweep();
    rd_exp_t e;
    logic    wexp;
    logic    bexp;
    for (int s = 0; s < N + 22 + 8; s++) begin
      bexp = (s >= 1) && (s <= N + 21);
      tests++;
      if (o_busy_r !== bexp) begin
        fails++;
        $display("[TB] FAIL rst_mid_sweep busy cycle %0d: got %b, expected %b", s, o_busy_r, bexp);
      end
      if (s == 0)            drive_step(0, 1, 0, 0, '0, 2'b00, 0, 0, bexp);
      else if (s == 21)      drive_step(1, 0, 0, 0, '0, 2'b00, 0, 0, bexp);
      else if (s == 30)      drive_step(0, 0, 1, 9, 32'h9999_9999, 2'b01, 9, 0, bexp);
      else if (s <= N + 21)  drive_step(0, 0, 0, 0, '0, 2'b00, 0, 0, bexp);
      else                   drive_step(0, 0, 0, 0, '0, 2'b11, s - N - 22, N - 1 - (s - N - 22), bexp);
      for (int p = 0; p < R; p++) begin
        e = rd_sb.pop_front();
        tests++;
        if (o_rvld_r[e.port] !== e.vld || o_rdata[e.port*W +: W] !== e.data ||
            (e.vld && o_rerr_r[e.port] !== e.err)) begin
          fails++;
          $display("[TB] FAIL rst_mid_sweep p%0d cycle %0d: got vld=%b err=%b data=%h, expected vld=%b err=%b data=%h",
                   e.port, s, o_rvld_r[e.port], o_rerr_r[e.port], o_rdata[e.port*W +: W], e.vld, e.err, e.data);
        end
      end
      wexp = wd_sb.pop_front();
      tests++;
      if (o_wdrop_r !== wexp) begin
        fails++;
        $display("[TB] FAIL rst_mid_sweep wdrop cycle %0d: got %b, expected %b", s, o_wdrop_r, wexp);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    i_init_req = 1'b0;
    i_wen      = 1'b0;
    i_waddr    = '0;
    i_wdata    = '0;
    i_ren      = '0;
    i_raddr    = '0;
    test_reset();
    test_init_contents();
    test_write_read();
    test_collision();
    test_out_of_range();
    test_reinit();
    test_rst_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
